gl_prim_assembler: RTL and testbench
====================================

# gl_prim_assembler

Primitive-assembly stage directly upstream of the rasterizer. Accepts a stream of single 96-bit vertices (x, y, z as IEEE-754 single, x in [95:64], y in [63:32], z in [31:0]), groups every three consecutive vertices into a triangle, and discards degenerate triangles. Surviving triangles are buffered in a small triangle FIFO. The head triangle is presented on `fifo_in1..3` with `fifo_ready`; the rasterizer pops it with a one-cycle done strobe.

## Interface
- `VERTEX_TYPE_SIZE`, 96, vertex word width.
- `DEPTH`, 4, triangle FIFO depth in triangles; power of two, ≥2.
- `clk`  in  1  sole clock; all logic on posedge.
- `rst_n`  in  1  synchronous, active-low reset.
- `vertex_valid`  in  1  `vertex_in` carries a vertex this cycle.
- `vertex_in`  in  VERTEX_TYPE_SIZE  incoming vertex.
- `vertex_ready`  out  1  vertex accepted when `vertex_valid && vertex_ready`.
- `flush`  in  1  discards the partially assembled triangle.
- `fifo_ready`  out  1  FIFO non-empty; head triangle valid.
- `fifo_in1`, `fifo_in2`, `fifo_in3`  out  VERTEX_TYPE_SIZE each  head triangle vertices, in arrival order.
- `raster_done`  in  1  one-cycle pulse: pop head triangle.
- `tri_count`  out  16  triangles pushed since reset; wraps.
- `drop_count`  out  16  degenerate triangles dropped since reset; wraps.

## Operation
- Assembly registers `v0`, `v1` plus a 2-bit `vert_cnt` (0, 1, 2). States: IDLE (cnt 0), HAVE1, HAVE2.
- Accepted vertex in IDLE goes to `v0`, then HAVE1. In HAVE1 it goes to `v1`, then HAVE2. In HAVE2 the triangle (`v0`, `v1`, `vertex_in`) is evaluated and the state returns to IDLE.
- Degenerate test, in HAVE2: any pair of vertices with bitwise-equal x and y fields. Degenerate triangle: not pushed, `drop_count` +1. Otherwise pushed, `tri_count` +1.
- `vertex_ready = !(vert_cnt == 2 && full)`. It is a function of registered state only; there is no combinational path from `raster_done`.
- `flush`: `vert_cnt` ← 0, and any vertex presented that cycle is discarded (flush wins). FIFO contents are untouched. `vertex_ready` stays as defined.
- Pop: `raster_done && !empty` advances the read pointer. `raster_done` while empty is ignored.
- Simultaneous push and pop: both take effect and occupancy is unchanged. Push while full cannot occur, because `vertex_ready` is low.
- Pointers: log2(DEPTH)+1 bits. Empty when the pointers are equal. Full when the MSBs differ and the rest are equal. Wrap-around is natural.
- `fifo_in1..3` are a combinational read of the head entry. When empty, they show the stale slot (reset value 0).

## Timing
- Reset (`rst_n` low at a posedge):
  - pointers, `vert_cnt`, `tri_count`, `drop_count` ← 0;
  - storage ← 0;
  - `fifo_ready` = 0, `fifo_in*` = 0;
  - `vertex_ready` = 1 on the cycle after release.
- Reset mid-triangle or with a non-empty FIFO discards everything.
- Latency: third vertex accepted at edge N, so `fifo_ready` is high after edge N (into an empty FIFO) and `tri_count` updates at edge N.
- Pop at edge N: the next head (or `fifo_ready` = 0) is visible after edge N.
- Throughput: 1 vertex/cycle when not full. Back-to-back pops on consecutive cycles are allowed.
- Full recovery: a pop at edge N makes `vertex_ready` rise after edge N. The stalled third vertex is accepted at N+1 at the earliest.

## Structure
- Shared package `gl_pkg`:
  - `VERTEX_TYPE_SIZE`;
  - field slice constants `VTX_X_MSB/LSB`, `VTX_Y_MSB/LSB`, `VTX_Z_MSB/LSB`;
  - vertex and triangle typedefs, shared with the rasterizer.
- One sub-module, `gl_tri_fifo`: a parameterised DEPTH × (3·VERTEX_TYPE_SIZE) synchronous-reset FIFO with push/pop/full/empty. Assembly, degenerate test and counters live in `gl_prim_assembler`.

## Test plan
- Reset then 3 vertices, x/y = (0,0), (4.0,0), (0,4.0) on consecutive cycles → `fifo_ready` high 1 cycle after the 3rd; `fifo_in1..3` match in order; `tri_count` = 1.
- Vertices (1.0,1.0), (1.0,1.0), (2.0,3.0) → no push, `fifo_ready` stays 0, `drop_count` = 1, `tri_count` = 0.
- 5 valid triangles, no `raster_done`, DEPTH = 4 → 4 pushed. `vertex_ready` drops while HAVE2 waits for the 5th triangle's 3rd vertex. One `raster_done` → next cycle `vertex_ready` = 1, 5th triangle accepted, order preserved across pointer wrap.
- FIFO holds 1 triangle; the 3rd vertex of a new triangle coincides with `raster_done` → occupancy stays 1; head becomes the new triangle.
- 2 vertices, then `flush` asserted with a 3rd vertex valid → vertex discarded, `vert_cnt` = 0. The next 3 vertices form one triangle.
- `rst_n` low with 2 triangles queued and 1 vertex pending → after release: `fifo_ready` = 0, `fifo_in*` = 0, counters 0, `vertex_ready` = 1.

Source files
------------

// File: rtl/gl_pkg.sv
// rtl/gl_pkg.sv - shared vertex/triangle types and field slices for the geometry pipeline
//
// Contents:
//   VERTEX_TYPE_SIZE            vertex word width (x, y, z IEEE-754 single)
//   VTX_{X,Y,Z}_{MSB,LSB}       field slice positions within a vertex word
//   vertex_t, triangle_t        shared with the rasterizer
//   asm_state_t                 assembly state; encoding equals the held-vertex count
//   xy_match()                  bitwise x/y equality of two vertices
package gl_pkg;

    localparam int VERTEX_TYPE_SIZE = 96;

    localparam int VTX_X_MSB = 95;
    localparam int VTX_X_LSB = 64;
    localparam int VTX_Y_MSB = 63;
    localparam int VTX_Y_LSB = 32;
    localparam int VTX_Z_MSB = 31;
    localparam int VTX_Z_LSB = 0;

    typedef logic [VERTEX_TYPE_SIZE-1:0] vertex_t;

    // First-arrived vertex occupies the most significant slot.
    typedef struct packed {
        vertex_t v1;
        vertex_t v2;
        vertex_t v3;
    } triangle_t;

    typedef enum logic [1:0] {
        ASM_IDLE  = 2'd0,
        ASM_HAVE1 = 2'd1,
        ASM_HAVE2 = 2'd2
    } asm_state_t;

    // Bitwise compare so that +0.0 / -0.0 and NaN payloads count as distinct.
    function automatic logic xy_match(input vertex_t a, input vertex_t b);
        return (a[VTX_X_MSB:VTX_X_LSB] == b[VTX_X_MSB:VTX_X_LSB]) &&
               (a[VTX_Y_MSB:VTX_Y_LSB] == b[VTX_Y_MSB:VTX_Y_LSB]);
    endfunction

endpackage

// File: rtl/gl_tri_fifo.sv
// rtl/gl_tri_fifo.sv - DEPTH-entry triangle FIFO with combinational head read
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset (clears storage too)
//   push, push_data  write one entry; ignored while full
//   pop              advance the read pointer; ignored while empty
//   head_data        entry at the read pointer (stale slot when empty)
//   full, empty      occupancy flags from registered pointers
module gl_tri_fifo #(
    parameter int WIDTH = 288,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices coincide.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/gl_prim_assembler.sv
// rtl/gl_prim_assembler.sv - groups vertices into triangles, drops degenerates, queues the rest
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   vertex_valid, vertex_in     incoming vertex stream
//   vertex_ready                vertex accepted on vertex_valid && vertex_ready
//   flush                       abandon the partially assembled triangle
//   fifo_ready                  head triangle valid
//   fifo_in1..fifo_in3          head triangle vertices in arrival order
//   raster_done                 one-cycle pop of the head triangle
//   tri_count, drop_count       pushed / degenerate triangle counters (wrap)
module gl_prim_assembler #(
    parameter int VERTEX_TYPE_SIZE = gl_pkg::VERTEX_TYPE_SIZE,
    parameter int DEPTH            = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        vertex_valid,
    input  logic [VERTEX_TYPE_SIZE-1:0] vertex_in,
    output logic                        vertex_ready,
    input  logic                        flush,
    output logic                        fifo_ready,
    output logic [VERTEX_TYPE_SIZE-1:0] fifo_in1,
    output logic [VERTEX_TYPE_SIZE-1:0] fifo_in2,
    output logic [VERTEX_TYPE_SIZE-1:0] fifo_in3,
    input  logic                        raster_done,
    output logic [15:0]                 tri_count,
    output logic [15:0]                 drop_count
);

    import gl_pkg::*;

    localparam int TRI_W = 3 * VERTEX_TYPE_SIZE;

    asm_state_t                  state;
    asm_state_t                  state_nxt;
    logic [VERTEX_TYPE_SIZE-1:0] v0;
    logic [VERTEX_TYPE_SIZE-1:0] v1;
    logic                        accept;
    logic                        degenerate;
    logic                        push;
    logic                        drop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [TRI_W-1:0]            head;

    // Stall only when a third vertex would need a slot that does not exist;
    // derived from registered state so raster_done never reaches this output.
    assign vertex_ready = !((state == ASM_HAVE2) && fifo_full);
    assign accept       = vertex_valid && vertex_ready && !flush;
    assign degenerate   = xy_match(v0, v1) || xy_match(v0, vertex_in) || xy_match(v1, vertex_in);

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        drop      = 1'b0;
        if (flush) begin
            state_nxt = ASM_IDLE;
        end else if (accept) begin
            case (state)
                ASM_IDLE:  state_nxt = ASM_HAVE1;
                ASM_HAVE1: state_nxt = ASM_HAVE2;
                ASM_HAVE2: begin
                    state_nxt = ASM_IDLE;
                    if (degenerate) begin
                        drop = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                default:   state_nxt = ASM_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ASM_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v0         <= '0;
            v1         <= '0;
            tri_count  <= '0;
            drop_count <= '0;
        end else begin
            if (accept && (state == ASM_IDLE)) begin
                v0 <= vertex_in;
            end
            if (accept && (state == ASM_HAVE1)) begin
                v1 <= vertex_in;
            end
            if (push) begin
                tri_count <= tri_count + 16'd1;
            end
            if (drop) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    gl_tri_fifo #(
        .WIDTH (TRI_W),
        .DEPTH (DEPTH)
    ) u_tri_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({v0, v1, vertex_in}),
        .pop       (raster_done),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign fifo_ready = !fifo_empty;
    assign fifo_in1   = head[TRI_W-1 -: VERTEX_TYPE_SIZE];
    assign fifo_in2   = head[2*VERTEX_TYPE_SIZE-1 -: VERTEX_TYPE_SIZE];
    assign fifo_in3   = head[VERTEX_TYPE_SIZE-1 -: VERTEX_TYPE_SIZE];

endmodule

// File: tb/tb_gl_prim_assembler.sv
// tb/tb_gl_prim_assembler.sv - self-checking bench for gl_prim_assembler
module tb_gl_prim_assembler;

    localparam int VW    = 96;
    localparam int DEPTH = 4;

    localparam logic [31:0] F0 = 32'h0000_0000;
    localparam logic [31:0] F1 = 32'h3F80_0000;
    localparam logic [31:0] F2 = 32'h4000_0000;
    localparam logic [31:0] F3 = 32'h4040_0000;
    localparam logic [31:0] F4 = 32'h4080_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vertex_valid;
    logic [VW-1:0] vertex_in;
    logic          vertex_ready;
    logic          flush;
    logic          fifo_ready;
    logic [VW-1:0] fifo_in1, fifo_in2, fifo_in3;
    logic          raster_done;
    logic [15:0]   tri_count, drop_count;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: queue of whole triangles plus list of pending vertices.
    logic [3*VW-1:0] mq[$];
    logic [VW-1:0]   pv[$];
    logic [15:0]     m_tri;
    logic [15:0]     m_drop;

    gl_prim_assembler #(.VERTEX_TYPE_SIZE(VW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vertex_valid (vertex_valid),
        .vertex_in    (vertex_in),
        .vertex_ready (vertex_ready),
        .flush        (flush),
        .fifo_ready   (fifo_ready),
        .fifo_in1     (fifo_in1),
        .fifo_in2     (fifo_in2),
        .fifo_in3     (fifo_in3),
        .raster_done  (raster_done),
        .tri_count    (tri_count),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic m_ready();
        return !(pv.size() == 2 && mq.size() == DEPTH);
    endfunction

    function automatic logic is_degen(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                      input logic [VW-1:0] c);
        return (a[95:32] == b[95:32]) || (a[95:32] == c[95:32]) || (b[95:32] == c[95:32]);
    endfunction

    function automatic logic [VW-1:0] rv();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [VW-1:0] mkv(input logic [31:0] x, input logic [31:0] y);
        return {x, y, $urandom()};
    endfunction

    task automatic drive(input logic vv, input logic [VW-1:0] vd, input logic fl, input logic dn);
        logic acc, pop_ok;
        vertex_valid = vv;
        vertex_in    = vd;
        flush        = fl;
        raster_done  = dn;
        acc    = vv && m_ready() && !fl;
        pop_ok = dn && (mq.size() != 0);
        @(posedge clk);
        if (fl) pv.delete();
        if (pop_ok) void'(mq.pop_front());
        if (acc) begin
            pv.push_back(vd);
            if (pv.size() == 3) begin
                if (is_degen(pv[0], pv[1], pv[2])) m_drop = m_drop + 16'd1;
                else begin
                    mq.push_back({pv[0], pv[1], pv[2]});
                    m_tri = m_tri + 16'd1;
                end
                pv.delete();
            end
        end
        #1;
        vertex_valid = 1'b0;
        flush        = 1'b0;
        raster_done  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mq.delete();
        pv.delete();
        m_tri  = '0;
        m_drop = '0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (fifo_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_fifo_ready: got %b want 0", fifo_ready); end
        tests_run++;
        if ({fifo_in1, fifo_in2, fifo_in3} !== '0) begin tests_failed++; $display("FAIL reset_fifo_in: got %h want 0", {fifo_in1, fifo_in2, fifo_in3}); end
        tests_run++;
        if (tri_count !== 16'd0 || drop_count !== 16'd0) begin tests_failed++; $display("FAIL reset_counts: got tri=%0d drop=%0d want 0/0", tri_count, drop_count); end
        tests_run++;
        if (vertex_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_vertex_ready: got %b want 1", vertex_ready); end
    endtask

    task automatic test_basic();
        logic [VW-1:0] a, b, c;
        do_reset();
        a = mkv(F0, F0); b = mkv(F4, F0); c = mkv(F0, F4);
        drive(1'b1, a, 1'b0, 1'b0);
        drive(1'b1, b, 1'b0, 1'b0);
        tests_run++;
        if (fifo_ready !== 1'b0) begin tests_failed++; $display("FAIL basic_early_ready: got %b want 0", fifo_ready); end
        drive(1'b1, c, 1'b0, 1'b0);
        tests_run++;
        if (fifo_ready !== 1'b1) begin tests_failed++; $display("FAIL basic_ready: got %b want 1", fifo_ready); end
        tests_run++;
        if ({fifo_in1, fifo_in2, fifo_in3} !== {a, b, c}) begin tests_failed++; $display("FAIL basic_head: got %h want %h", {fifo_in1, fifo_in2, fifo_in3}, {a, b, c}); end
        tests_run++;
        if (tri_count !== 16'd1 || drop_count !== 16'd0) begin tests_failed++; $display("FAIL basic_counts: got tri=%0d drop=%0d want 1/0", tri_count, drop_count); end
        drive(1'b0, '0, 1'b0, 1'b1);
        tests_run++;
        if (fifo_ready !== 1'b0) begin tests_failed++; $display("FAIL basic_pop_empty: got %b want 0", fifo_ready); end
        drive(1'b0, '0, 1'b0, 1'b1);
        tests_run++;
        if (fifo_ready !== 1'b0 || tri_count !== 16'd1) begin tests_failed++; $display("FAIL basic_pop_when_empty: got ready=%b tri=%0d want 0/1", fifo_ready, tri_count); end
    endtask

    task automatic test_degenerate();
        do_reset();
        drive(1'b1, mkv(F1, F1), 1'b0, 1'b0);
        drive(1'b1, mkv(F1, F1), 1'b0, 1'b0);
        drive(1'b1, mkv(F2, F3), 1'b0, 1'b0);
        tests_run++;
        if (fifo_ready !== 1'b0) begin tests_failed++; $display("FAIL degen_ready: got %b want 0", fifo_ready); end
        tests_run++;
        if (drop_count !== 16'd1 || tri_count !== 16'd0) begin tests_failed++; $display("FAIL degen_counts: got tri=%0d drop=%0d want 0/1", tri_count, drop_count); end
        // Pair v0/v2 equal: also degenerate; z differences do not matter.
        drive(1'b1, mkv(F2, F1), 1'b0, 1'b0);
        drive(1'b1, mkv(F3, F3), 1'b0, 1'b0);
        drive(1'b1, mkv(F2, F1), 1'b0, 1'b0);
        tests_run++;
        if (drop_count !== 16'd2 || fifo_ready !== 1'b0) begin tests_failed++; $display("FAIL degen_v0v2: got drop=%0d ready=%b want 2/0", drop_count, fifo_ready); end
    endtask

    task automatic test_full_wrap();
        logic [VW-1:0] vtx [15];
        do_reset();
        for (int i = 0; i < 15; i++) vtx[i] = rv();
        for (int i = 0; i < 14; i++) drive(1'b1, vtx[i], 1'b0, 1'b0);
        tests_run++;
        if (vertex_ready !== 1'b0 || tri_count !== 16'd4) begin tests_failed++; $display("FAIL full_stall: got ready=%b tri=%0d want 0/4", vertex_ready, tri_count); end
        drive(1'b1, vtx[14], 1'b0, 1'b0);
        tests_run++;
        if (vertex_ready !== 1'b0 || tri_count !== 16'd4) begin tests_failed++; $display("FAIL full_hold: got ready=%b tri=%0d want 0/4", vertex_ready, tri_count); end
        drive(1'b1, vtx[14], 1'b0, 1'b1);
        tests_run++;
        if (vertex_ready !== 1'b1 || tri_count !== 16'd4) begin tests_failed++; $display("FAIL full_recover: got ready=%b tri=%0d want 1/4", vertex_ready, tri_count); end
        drive(1'b1, vtx[14], 1'b0, 1'b0);
        tests_run++;
        if (tri_count !== 16'd5) begin tests_failed++; $display("FAIL full_fifth: got tri=%0d want 5", tri_count); end
        for (int t = 1; t < 5; t++) begin
            tests_run++;
            if (fifo_ready !== 1'b1 || {fifo_in1, fifo_in2, fifo_in3} !== {vtx[3*t], vtx[3*t+1], vtx[3*t+2]}) begin
                tests_failed++;
                $display("FAIL full_order[%0d]: got ready=%b %h want %h", t, fifo_ready, {fifo_in1, fifo_in2, fifo_in3}, {vtx[3*t], vtx[3*t+1], vtx[3*t+2]});
            end
            drive(1'b0, '0, 1'b0, 1'b1);
        end
        tests_run++;
        if (fifo_ready !== 1'b0) begin tests_failed++; $display("FAIL full_drained: got %b want 0", fifo_ready); end
    endtask

    task automatic test_push_pop();
        logic [VW-1:0] b0, b1, b2;
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, rv(), 1'b0, 1'b0);
        b0 = rv(); b1 = rv(); b2 = rv();
        drive(1'b1, b0, 1'b0, 1'b0);
        drive(1'b1, b1, 1'b0, 1'b0);
        drive(1'b1, b2, 1'b0, 1'b1);
        tests_run++;
        if (fifo_ready !== 1'b1 || {fifo_in1, fifo_in2, fifo_in3} !== {b0, b1, b2}) begin
            tests_failed++;
            $display("FAIL pushpop_head: got ready=%b %h want %h", fifo_ready, {fifo_in1, fifo_in2, fifo_in3}, {b0, b1, b2});
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        tests_run++;
        if (fifo_ready !== 1'b0 || tri_count !== 16'd2) begin tests_failed++; $display("FAIL pushpop_occupancy: got ready=%b tri=%0d want 0/2", fifo_ready, tri_count); end
    endtask

    task automatic test_flush();
        logic [VW-1:0] d, e, f;
        do_reset();
        drive(1'b1, rv(), 1'b0, 1'b0);
        drive(1'b1, rv(), 1'b0, 1'b0);
        drive(1'b1, rv(), 1'b1, 1'b0);
        tests_run++;
        if (tri_count !== 16'd0 || drop_count !== 16'd0 || fifo_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_discard: got tri=%0d drop=%0d ready=%b want 0/0/0", tri_count, drop_count, fifo_ready);
        end
        d = rv(); e = rv(); f = rv();
        drive(1'b1, d, 1'b0, 1'b0);
        drive(1'b1, e, 1'b0, 1'b0);
        drive(1'b1, f, 1'b0, 1'b0);
        tests_run++;
        if (tri_count !== 16'd1 || {fifo_in1, fifo_in2, fifo_in3} !== {d, e, f}) begin
            tests_failed++;
            $display("FAIL flush_next_tri: got tri=%0d %h want 1 %h", tri_count, {fifo_in1, fifo_in2, fifo_in3}, {d, e, f});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 7; i++) drive(1'b1, rv(), 1'b0, 1'b0);
        tests_run++;
        if (tri_count !== 16'd2 || fifo_ready !== 1'b1) begin tests_failed++; $display("FAIL midreset_setup: got tri=%0d ready=%b want 2/1", tri_count, fifo_ready); end
        do_reset();
        tests_run++;
        if (fifo_ready !== 1'b0 || {fifo_in1, fifo_in2, fifo_in3} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_fifo: got ready=%b %h want 0 0", fifo_ready, {fifo_in1, fifo_in2, fifo_in3});
        end
        tests_run++;
        if (tri_count !== 16'd0 || drop_count !== 16'd0 || vertex_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_state: got tri=%0d drop=%0d vready=%b want 0/0/1", tri_count, drop_count, vertex_ready);
        end
        // The pending vertex must be gone: three fresh vertices form exactly one triangle.
        for (int i = 0; i < 3; i++) drive(1'b1, rv(), 1'b0, 1'b0);
        tests_run++;
        if (tri_count !== 16'd1) begin tests_failed++; $display("FAIL midreset_pending: got tri=%0d want 1", tri_count); end
    endtask

    task automatic test_random();
        logic          vv, fl, dn;
        logic [VW-1:0] vd;
        do_reset();
        for (int it = 0; it < 500; it++) begin
            vv = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 29) == 0);
            dn = ($urandom_range(0, 2) == 0);
            vd = rv();
            if (pv.size() != 0 && $urandom_range(0, 4) == 0) vd = {pv[0][95:32], vd[31:0]};
            drive(vv, vd, fl, dn);
            tests_run++;
            if (vertex_ready !== m_ready()) begin tests_failed++; $display("FAIL rand_vready[%0d]: got %b want %b", it, vertex_ready, m_ready()); end
            tests_run++;
            if (fifo_ready !== (mq.size() != 0)) begin tests_failed++; $display("FAIL rand_fifo_ready[%0d]: got %b want %b", it, fifo_ready, mq.size() != 0); end
            tests_run++;
            if (tri_count !== m_tri || drop_count !== m_drop) begin
                tests_failed++;
                $display("FAIL rand_counts[%0d]: got tri=%0d drop=%0d want %0d/%0d", it, tri_count, drop_count, m_tri, m_drop);
            end
            if (mq.size() != 0) begin
                tests_run++;
                if ({fifo_in1, fifo_in2, fifo_in3} !== mq[0]) begin
                    tests_failed++;
                    $display("FAIL rand_head[%0d]: got %h want %h", it, {fifo_in1, fifo_in2, fifo_in3}, mq[0]);
                end
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        vertex_valid = 1'b0;
        vertex_in    = '0;
        flush        = 1'b0;
        raster_done  = 1'b0;
        m_tri        = '0;
        m_drop       = '0;
        test_reset();
        test_basic();
        test_degenerate();
        test_full_wrap();
        test_push_pop();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
